// File: rtl/mpc_hfill_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mpc_hfill_pkg                                              |
// | Description : Shared types and constants for the h-vector fill           |
// |               sequencer: FSM state enum, segment descriptor struct,      |
// |               datapath widths and the default bound value.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mpc_hfill_pkg;

  localparam int HFILL_AW    = 5;   // h RAM address width
  localparam int HFILL_DW    = 21;  // h RAM data width
  localparam int HFILL_IW    = 2;   // segment index width
  localparam int HFILL_NSEG  = 4;   // segments in the table
  localparam int HFILL_DEPTH = 18;  // valid h entries
  localparam int HFILL_STW   = 2;   // FSM state width

  localparam logic [HFILL_DW-1:0] HFILL_DEF_VAL = 21'd163840;

  typedef enum logic [HFILL_STW-1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } hfill_state_e;

  typedef struct packed {
    logic [HFILL_AW-1:0] base;
    logic [HFILL_AW-1:0] len;
    logic [HFILL_DW-1:0] val;
  } seg_t;

  // True when the (already wrapped) address lies inside the populated part of h.
  function automatic logic hfill_addr_ok(input logic [HFILL_AW-1:0] addr,
                                         input int unsigned depth);
    return {{(32-HFILL_AW){1'b0}}, addr} < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpc_hfill_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mpc_hfill_sched_if                                         |
// | Description : Bundle of the fill sequencer's control handshake, h RAM    |
// |               write port and (when MPC_HFILL_CFG_EN is defined) the      |
// |               segment-table configuration port.                          |
// |   master : drives ap_start / cfg_*, receives ap_* status and h_* port    |
// |   slave  : the sequencer side                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mpc_hfill_sched_if;
  import mpc_hfill_pkg::*;

  logic                ap_start;
  logic                ap_done;
  logic                ap_idle;
  logic                ap_ready;
  logic [HFILL_AW-1:0] h_address0;
  logic                h_ce0;
  logic                h_we0;
  logic [HFILL_DW-1:0] h_d0;
`ifdef MPC_HFILL_CFG_EN
  logic                cfg_we;
  logic [HFILL_IW-1:0] cfg_sel;
  logic [HFILL_AW-1:0] cfg_base;
  logic [HFILL_AW-1:0] cfg_len;
  logic [HFILL_DW-1:0] cfg_val;

  modport master (
    output ap_start, cfg_we, cfg_sel, cfg_base, cfg_len, cfg_val,
    input  ap_done, ap_idle, ap_ready, h_address0, h_ce0, h_we0, h_d0
  );
  modport slave (
    input  ap_start, cfg_we, cfg_sel, cfg_base, cfg_len, cfg_val,
    output ap_done, ap_idle, ap_ready, h_address0, h_ce0, h_we0, h_d0
  );
`else
  modport master (
    output ap_start,
    input  ap_done, ap_idle, ap_ready, h_address0, h_ce0, h_we0, h_d0
  );
  modport slave (
    input  ap_start,
    output ap_done, ap_idle, ap_ready, h_address0, h_ce0, h_we0, h_d0
  );
`endif

endinterface
`default_nettype wire

// File: rtl/mpc_hfill_seg_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mpc_hfill_seg_table                                        |
// | Description : Segment descriptor store for the h fill sequencer.         |
// |               MPC_HFILL_CFG_EN undefined: constant table built from the  |
// |               parameters. Defined: registered table reset to the         |
// |               parameter values, with one write port.                     |
// | Ports       : rd_idx/rd_seg   - combinational read port                  |
// |               clk, rst_n, wr_en, wr_sel, wr_seg - write port (CFG only)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mpc_hfill_seg_table
  import mpc_hfill_pkg::*;
#(
  parameter int unsigned         SEG0_BASE = 0,
  parameter int unsigned         SEG0_LEN  = 5,
  parameter logic [HFILL_DW-1:0] SEG0_VAL  = HFILL_DEF_VAL,
  parameter int unsigned         SEG1_BASE = 5,
  parameter int unsigned         SEG1_LEN  = 5,
  parameter logic [HFILL_DW-1:0] SEG1_VAL  = HFILL_DEF_VAL,
  parameter int unsigned         SEG2_BASE = 10,
  parameter int unsigned         SEG2_LEN  = 5,
  parameter logic [HFILL_DW-1:0] SEG2_VAL  = HFILL_DEF_VAL,
  parameter int unsigned         SEG3_BASE = 15,
  parameter int unsigned         SEG3_LEN  = 3,
  parameter logic [HFILL_DW-1:0] SEG3_VAL  = HFILL_DEF_VAL
) (
`ifdef MPC_HFILL_CFG_EN
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                wr_en,
  input  wire logic [HFILL_IW-1:0] wr_sel,
  input  wire seg_t                wr_seg,
`endif
  input  wire logic [HFILL_IW-1:0] rd_idx,
  output seg_t                     rd_seg
);

  localparam seg_t C_DEF [HFILL_NSEG] = '{
    '{base: HFILL_AW'(SEG0_BASE), len: HFILL_AW'(SEG0_LEN), val: SEG0_VAL},
    '{base: HFILL_AW'(SEG1_BASE), len: HFILL_AW'(SEG1_LEN), val: SEG1_VAL},
    '{base: HFILL_AW'(SEG2_BASE), len: HFILL_AW'(SEG2_LEN), val: SEG2_VAL},
    '{base: HFILL_AW'(SEG3_BASE), len: HFILL_AW'(SEG3_LEN), val: SEG3_VAL}
  };

`ifdef MPC_HFILL_CFG_EN
  seg_t tbl_q [HFILL_NSEG];
  seg_t tbl_d [HFILL_NSEG];

  always_comb begin
    tbl_d = tbl_q;
    if (wr_en) begin
      tbl_d[wr_sel] = wr_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_q <= C_DEF;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rd_seg = tbl_q[rd_idx];
`else
  assign rd_seg = C_DEF[rd_idx];
`endif

endmodule
`default_nettype wire

// File: rtl/mpc_hfill_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mpc_hfill_sched                                            |
// | Description : Table-driven sequencer that fills the dense-constraint     |
// |               vector h with constant bounds, one segment at a time,      |
// |               through the single h RAM write port.                       |
// | Ports       : ap_clk   - clock                                           |
// |               ap_rst_n - synchronous active-low reset                    |
// |               bus      - mpc_hfill_sched_if.slave: ap_start/done/idle/   |
// |                          ready handshake, h_address0/ce0/we0/d0 RAM port,|
// |                          cfg_* table write port (MPC_HFILL_CFG_EN only)  |
// | Macro       : MPC_HFILL_CFG_EN - runtime-writable segment table          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mpc_hfill_sched
  import mpc_hfill_pkg::*;
#(
  parameter int unsigned         NUM_SEG   = HFILL_NSEG,
  parameter int unsigned         H_DEPTH   = HFILL_DEPTH,
  parameter int unsigned         SEG0_BASE = 0,
  parameter int unsigned         SEG0_LEN  = 5,
  parameter logic [HFILL_DW-1:0] SEG0_VAL  = HFILL_DEF_VAL,
  parameter int unsigned         SEG1_BASE = 5,
  parameter int unsigned         SEG1_LEN  = 5,
  parameter logic [HFILL_DW-1:0] SEG1_VAL  = HFILL_DEF_VAL,
  parameter int unsigned         SEG2_BASE = 10,
  parameter int unsigned         SEG2_LEN  = 5,
  parameter logic [HFILL_DW-1:0] SEG2_VAL  = HFILL_DEF_VAL,
  parameter int unsigned         SEG3_BASE = 15,
  parameter int unsigned         SEG3_LEN  = 3,
  parameter logic [HFILL_DW-1:0] SEG3_VAL  = HFILL_DEF_VAL
) (
  input wire logic         ap_clk,
  input wire logic         ap_rst_n,
  mpc_hfill_sched_if.slave bus
);

  localparam logic [HFILL_IW-1:0] C_LAST_IDX = HFILL_IW'(NUM_SEG - 1);

  hfill_state_e        state_q, state_d;
  logic [HFILL_IW-1:0] seg_idx_q, seg_idx_d;
  logic [HFILL_AW-1:0] cnt_q, cnt_d;
  seg_t                cur_q, cur_d;     // segment latched in LOAD
  seg_t                tbl_seg;
  logic                is_last;
  logic                cnt_end;
  logic [HFILL_AW-1:0] wr_addr;
  logic                wr_ok;

`ifdef MPC_HFILL_CFG_EN
  // Table writes are only honoured while idle and not starting, so a fill
  // never sees a table that changes underneath it.
  logic cfg_wr;
  seg_t cfg_seg;
  assign cfg_wr  = bus.cfg_we && (state_q == ST_IDLE) && !bus.ap_start;
  assign cfg_seg = '{base: bus.cfg_base, len: bus.cfg_len, val: bus.cfg_val};
`endif

  mpc_hfill_seg_table #(
    .SEG0_BASE (SEG0_BASE), .SEG0_LEN (SEG0_LEN), .SEG0_VAL (SEG0_VAL),
    .SEG1_BASE (SEG1_BASE), .SEG1_LEN (SEG1_LEN), .SEG1_VAL (SEG1_VAL),
    .SEG2_BASE (SEG2_BASE), .SEG2_LEN (SEG2_LEN), .SEG2_VAL (SEG2_VAL),
    .SEG3_BASE (SEG3_BASE), .SEG3_LEN (SEG3_LEN), .SEG3_VAL (SEG3_VAL)
  ) u_seg_table (
`ifdef MPC_HFILL_CFG_EN
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .wr_en  (cfg_wr),
    .wr_sel (bus.cfg_sel),
    .wr_seg (cfg_seg),
`endif
    .rd_idx (seg_idx_q),
    .rd_seg (tbl_seg)
  );

  assign is_last = (seg_idx_q == C_LAST_IDX);
  // len is non-zero whenever WRITE is entered, so len-1 never underflows here.
  assign cnt_end = (cnt_q == (cur_q.len - HFILL_AW'(1)));
  // 5-bit add: addresses wrap modulo 32 by construction.
  assign wr_addr = cur_q.base + cnt_q;
  assign wr_ok   = hfill_addr_ok(wr_addr, H_DEPTH);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      seg_idx_q <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ap_start) begin
          seg_idx_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cur_d = tbl_seg;
        cnt_d = '0;
        if (tbl_seg.len == '0) begin
          // Empty segment costs exactly this one LOAD cycle.
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            seg_idx_d = seg_idx_q + HFILL_IW'(1);
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cnt_end) begin
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            seg_idx_d = seg_idx_q + HFILL_IW'(1);
            state_d   = ST_LOAD;
          end
        end else begin
          cnt_d = cnt_q + HFILL_AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.ap_idle    = 1'b0;
    bus.ap_done    = 1'b0;
    bus.ap_ready   = 1'b0;
    bus.h_address0 = '0;
    bus.h_ce0      = 1'b0;
    bus.h_we0      = 1'b0;
    bus.h_d0       = '0;
    case (state_q)
      ST_IDLE: begin
        bus.ap_idle = 1'b1;
      end
      ST_WRITE: begin
        // Out-of-range cycles still present address/data but keep the RAM
        // disabled, so the cycle is spent without touching h.
        bus.h_address0 = wr_addr;
        bus.h_d0       = cur_q.val;
        bus.h_ce0      = wr_ok;
        bus.h_we0      = wr_ok;
      end
      ST_DONE: begin
        bus.ap_done  = 1'b1;
        bus.ap_ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mpc_hfill_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mpc_hfill_sched                                         |
// | Description : Self-checking bench for mpc_hfill_sched. Two instances:    |
// |               u_dut0 uses the default table; u_dut1 has a zero-length    |
// |               middle segment, an out-of-range segment (base 16, len 4)   |
// |               and a zero-length last segment. Expected per-cycle output  |
// |               vectors are queued by a reference model when a fill is     |
// |               started and compared every cycle on the falling edge.      |
// | Macro       : MPC_HFILL_CFG_EN - adds the table-configuration scenarios  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mpc_hfill_sched;
  import mpc_hfill_pkg::*;

  // {idle, done, ready, ce, we, addr[4:0], d[20:0]}
  typedef logic [30:0] obs_t;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  mpc_hfill_sched_if bus0 ();
  mpc_hfill_sched_if bus1 ();

  mpc_hfill_sched u_dut0 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus0)
  );

  mpc_hfill_sched #(
    .SEG1_LEN  (0),
    .SEG2_BASE (16),
    .SEG2_LEN  (4),
    .SEG3_LEN  (0)
  ) u_dut1 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t mk(input logic idle, input logic done, input logic ce,
                              input logic [4:0] addr, input logic [20:0] d);
    return {idle, done, done, ce, ce, addr, d};
  endfunction

  localparam obs_t C_IDLE_V = 31'h4000_0000;
  localparam obs_t C_ZERO_V = 31'h0000_0000;

  // Reference copy of each instance's segment table.
  int          tb_base [2][4];
  int          tb_len  [2][4];
  logic [20:0] tb_val  [2][4];

  obs_t q0[$];
  obs_t q1[$];

  task automatic push_exp(input int d, input obs_t v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // One fill as seen from the cycle after the start edge.
  task automatic push_fill(input int d);
    for (int s = 0; s < 4; s++) begin
      push_exp(d, C_ZERO_V);  // LOAD
      for (int i = 0; i < tb_len[d][s]; i++) begin
        int   a;
        logic ok;
        a  = (tb_base[d][s] + i) % 32;
        ok = (a < 18);
        push_exp(d, mk(1'b0, 1'b0, ok, 5'(a), tb_val[d][s]));
      end
    end
    push_exp(d, mk(1'b0, 1'b1, 1'b0, 5'd0, 21'd0));  // DONE
  endtask

  obs_t obs0, obs1;
  assign obs0 = {bus0.ap_idle, bus0.ap_done, bus0.ap_ready, bus0.h_ce0, bus0.h_we0,
                 bus0.h_address0, bus0.h_d0};
  assign obs1 = {bus1.ap_idle, bus1.ap_done, bus1.ap_ready, bus1.h_ce0, bus1.h_we0,
                 bus1.h_address0, bus1.h_d0};

  int   cyc = 0;
  int   t0  = 0;
  bit   mon_en = 1'b0;
  int   wcnt0, wcnt1, dcnt0, dcnt1, done_at0, done_at1;
  obs_t exp0, exp1;

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk) begin
    if (mon_en) begin
      if (q0.size() != 0) exp0 = q0.pop_front();
      else                exp0 = C_IDLE_V;
      if (q1.size() != 0) exp1 = q1.pop_front();
      else                exp1 = C_IDLE_V;
      check_eq($sformatf("dut0_c%0d", cyc - t0), {1'b0, obs0}, {1'b0, exp0});
      check_eq($sformatf("dut1_c%0d", cyc - t0), {1'b0, obs1}, {1'b0, exp1});
      if (bus0.h_we0)   wcnt0++;
      if (bus1.h_we0)   wcnt1++;
      if (bus0.ap_done) begin dcnt0++; done_at0 = cyc - t0; end
      if (bus1.ap_done) begin dcnt1++; done_at1 = cyc - t0; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic clr_stats();
    wcnt0 = 0; wcnt1 = 0; dcnt0 = 0; dcnt1 = 0; done_at0 = -1; done_at1 = -1;
  endtask

  // Called at the start of cycle 0 (start sampled at its closing edge).
  task automatic start_fill(input bit s0, input bit s1);
    clr_stats();
    t0 = cyc;
    bus0.ap_start = s0;
    bus1.ap_start = s1;
    push_exp(0, C_IDLE_V);
    push_exp(1, C_IDLE_V);
    if (s0) push_fill(0);
    if (s1) push_fill(1);
    tick(1);
    bus0.ap_start = 1'b0;
    bus1.ap_start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
      tick(1);
      k++;
    end
    check_eq("drain", 32'(q0.size() + q1.size()), 32'd0);
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int s = 0; s < 4; s++) begin
      tb_base[0][s] = 5 * s;
      tb_len[0][s]  = (s == 3) ? 3 : 5;
      tb_val[0][s]  = 21'd163840;
      tb_val[1][s]  = 21'd163840;
    end
    tb_base[1][0] = 0;  tb_len[1][0] = 5;
    tb_base[1][1] = 5;  tb_len[1][1] = 0;
    tb_base[1][2] = 16; tb_len[1][2] = 4;
    tb_base[1][3] = 15; tb_len[1][3] = 0;

    bus0.ap_start = 1'b0;
    bus1.ap_start = 1'b0;
`ifdef MPC_HFILL_CFG_EN
    bus0.cfg_we = 1'b0; bus0.cfg_sel = '0; bus0.cfg_base = '0; bus0.cfg_len = '0; bus0.cfg_val = '0;
    bus1.cfg_we = 1'b0; bus1.cfg_sel = '0; bus1.cfg_base = '0; bus1.cfg_len = '0; bus1.cfg_val = '0;
`endif
    clr_stats();

    // Reset state is checked while reset is still held.
    tick(1);
    mon_en = 1'b1;
    tick(2);
    ap_rst_n = 1'b1;
    tick(2);

    // Default fill on dut0; zero-length and out-of-range segments on dut1.
    start_fill(1'b1, 1'b1);
    drain();
    check_eq("def_writes",  32'(wcnt0),    32'd18);
    check_eq("def_dones",   32'(dcnt0),    32'd1);
    check_eq("def_done_at", 32'(done_at0), 32'd23);
    check_eq("oor_writes",  32'(wcnt1),    32'd7);
    check_eq("oor_dones",   32'(dcnt1),    32'd1);
    check_eq("oor_done_at", 32'(done_at1), 32'd14);

    // Reset asserted during cycle 10 of a fill.
    start_fill(1'b1, 1'b0);
    tick(9);
    ap_rst_n = 1'b0;
    tick(1);
    q0.delete();
    ap_rst_n = 1'b1;
    tick(4);
    check_eq("rst_writes", 32'(wcnt0), 32'd8);
    check_eq("rst_dones",  32'(dcnt0), 32'd0);

    // A fresh start after the abort runs a complete fill.
    start_fill(1'b1, 1'b0);
    drain();
    check_eq("refill_writes",  32'(wcnt0),    32'd18);
    check_eq("refill_done_at", 32'(done_at0), 32'd23);

    // Back-to-back: start held until the second fill's LOAD cycle.
    clr_stats();
    t0 = cyc;
    bus0.ap_start = 1'b1;
    push_exp(0, C_IDLE_V);
    push_fill(0);
    push_exp(0, C_IDLE_V);
    push_fill(0);
    tick(25);
    bus0.ap_start = 1'b0;
    drain();
    check_eq("b2b_writes",  32'(wcnt0),    32'd36);
    check_eq("b2b_dones",   32'(dcnt0),    32'd2);
    check_eq("b2b_done_at", 32'(done_at0), 32'd47);

`ifdef MPC_HFILL_CFG_EN
    // Table write during WRITE is dropped.
    start_fill(1'b1, 1'b0);
    tick(4);
    bus0.cfg_we = 1'b1; bus0.cfg_sel = 2'd0; bus0.cfg_base = 5'd0;
    bus0.cfg_len = 5'd5; bus0.cfg_val = 21'd5;
    tick(1);
    bus0.cfg_we = 1'b0;
    drain();
    start_fill(1'b1, 1'b0);
    drain();
    check_eq("cfg_busy_writes", 32'(wcnt0), 32'd18);

    // Same write in IDLE takes effect for the next fill.
    bus0.cfg_we = 1'b1;
    tick(1);
    bus0.cfg_we = 1'b0;
    tb_val[0][0] = 21'd5;
    start_fill(1'b1, 1'b0);
    drain();
    check_eq("cfg_idle_writes", 32'(wcnt0), 32'd18);
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mpc_hfill_sched.md
# mpc_hfill_sched

Sequencer that fills the dense-constraint vector `h` with constant bound values, segment by segment, through the single write port of the `h` RAM. It replaces the per-segment fill loops with one table-driven controller. It sits inside the dense-constraint stage and is started by the top-level MPC FSM before the QP solve. An `ap_start`/`ap_done` handshake starts each fill. Each segment is a contiguous run of `h` addresses written with one 21-bit value.

## Interface
- `NUM_SEG`, 4: number of segments in the table (index width 2).
- `H_DEPTH`, 18: valid `h` entries; addresses ≥ `H_DEPTH` are never written.
- `SEGk_BASE` / `SEGk_LEN` / `SEGk_VAL` (k = 0..3), defaults:
  - k = 0: 0 / 5 / 163840
  - k = 1: 5 / 5 / 163840
  - k = 2: 10 / 5 / 163840
  - k = 3: 15 / 3 / 163840
- `ap_clk` in 1: the only clock.
- `ap_rst_n` in 1: synchronous, active-low reset.
- `ap_start` in 1: request a fill; sampled in IDLE only.
- `ap_done` out 1: one-cycle pulse when the fill completes.
- `ap_idle` out 1: high in IDLE.
- `ap_ready` out 1: one-cycle pulse, same cycle as `ap_done`.
- `h_address0` out 5: RAM address.
- `h_ce0` out 1: RAM enable.
- `h_we0` out 1: RAM write enable.
- `h_d0` out 21: RAM write data.
- Ports present only under `MPC_HFILL_CFG_EN`:
  - `cfg_we` in 1
  - `cfg_sel` in 2
  - `cfg_base` in 5
  - `cfg_len` in 5
  - `cfg_val` in 21

## Operation
- FSM states are IDLE, LOAD, WRITE and DONE.
- **IDLE**
  - `ap_idle`=1 and `h_ce0`=`h_we0`=0.
  - When `ap_start`=1: `seg_idx`←0, go to LOAD.
- **LOAD**: latch base, len and val of `seg_idx`; `cnt`←0. Next state:
  - len=0 and the segment is last → DONE.
  - len=0 and not last → `seg_idx`+1, stay in LOAD.
  - otherwise → WRITE.
- **WRITE** (one write per cycle)
  - `h_ce0`=1, `h_address0`=base+`cnt` (5-bit add, wraps mod 32), `h_d0`=val.
  - `h_we0`=1 only if base+`cnt` < `H_DEPTH`. Out-of-range cycles are still spent and counted, and `h_ce0` is also 0 in those cycles.
  - When `cnt`=len−1: go to DONE if the segment is last, else `seg_idx`+1 and go to LOAD. Otherwise `cnt`+1.
- **DONE**: `ap_done`=`ap_ready`=1 for one cycle, then go to IDLE. `ap_start` held high starts a new fill on the following IDLE cycle.
- Segments overlap freely; a later segment overwrites an earlier one at the same address.
- `h_address0` and `h_d0` drive 0 outside WRITE.

## Timing
- Reset values: state IDLE, `ap_idle`=1, all other outputs 0, `seg_idx`=`cnt`=0, table = parameter defaults.
- Asserting `ap_rst_n`=0 mid-fill aborts on the next edge with no `ap_done` pulse. A partially filled `h` is acceptable.
- Latency: start sampled at edge 0, so `ap_done` is asserted in cycle 1 + Σ(1 + len_k) + 0. With defaults, writes occupy cycles 2–6, 8–12, 14–18 and 20–22, and `ap_done` is in cycle 23.
- No backpressure: the RAM accepts a write every cycle.

## Configuration
- `MPC_HFILL_CFG_EN` defined:
  - Table entries are registers, reset to the parameter defaults.
  - `cfg_we`=1 in IDLE, without `ap_start` in the same cycle, writes entry `cfg_sel` at the next edge.
  - `cfg_we` is silently dropped in any other state, or together with `ap_start`, so a fill always uses a consistent table.
- Undefined: the `cfg_*` ports are absent and the table is constant from the parameters.

## Structure
- Package `mpc_hfill_pkg` holds:
  - the state enum;
  - a `seg_t` struct (base[4:0], len[4:0], val[20:0]);
  - the width constants;
  - the default bound value `HFILL_DEF_VAL`=163840.
- Sub-module `mpc_hfill_seg_table` is the segment store:
  - read port indexed by `seg_idx`;
  - optional write port under `MPC_HFILL_CFG_EN`;
  - constant or registered storage depending on the macro.

## Test plan
- **Default fill**: reset, pulse `ap_start` → 18 writes, addr 0..17, all `h_d0`=163840. `ap_done` in cycle 23, single pulse, `ap_idle` back high in cycle 24.
- **Zero-length segment**: CFG seg1 len=0 → seg1 costs one LOAD cycle with no write, 13 writes total, `ap_done` in cycle 18.
- **Out-of-range**: seg3 base=16, len=4 → address 19 has `h_we0`=0, address 18 also suppressed. Cycle count unchanged versus len=4.
- **Reset mid-fill**: drop `ap_rst_n` in cycle 10 → next cycle all outputs at reset values, no `ap_done`. A fresh `ap_start` performs a complete fill.
- **Config while busy**: `cfg_we` with seg0 val=5 during WRITE → ignored, current and next fill use 163840. The same write in IDLE → next fill writes 5 to addr 0..4.
- **Back-to-back**: `ap_start` held high → second fill begins the cycle after the IDLE cycle following DONE, with identical write sequence.
